// File: rtl/nf_bus_pkg.sv
// Shared types for the nanoFOX bus arbiter and future bridges.
// Holds the FSM states, the transaction owner encoding and the access size codes.
package nf_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_I) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/nf_bus_wdog.sv
// Bus watchdog: counts enabled cycles and flags expiry on the TIMEOUT-th one; TIMEOUT = 0 never expires.
// No latency beyond the count itself; clear has priority over enable, no backpressure.
module nf_bus_wdog #(
  parameter int TW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TW-1:0] LIMIT = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TW'(1);
    end
  end

  // Expiry is judged on the cycle holding TIMEOUT-1, so the waiting phase lasts exactly TIMEOUT cycles.
  assign expire = (TIMEOUT != 0) && en && (count == LIMIT);

endmodule

// File: rtl/nf_bus_arb.sv
// Round-robin arbiter sharing one slave bus between the fetch and load/store ports, one transaction at a time.
// Latency: bus_req one cycle after grant, requester ack one cycle after bus_ack/timeout; requests wait while busy.
module nf_bus_arb
  import nf_bus_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          instr_req,
  input  logic [AW-1:0] instr_addr,
  output logic          instr_ack,
  output logic [DW-1:0] instr_rd,
  output logic          instr_err,
  input  logic          data_req,
  input  logic [AW-1:0] data_addr,
  input  logic          data_we,
  input  logic [DW-1:0] data_wd,
  input  logic [1:0]    data_size,
  output logic          data_ack,
  output logic [DW-1:0] data_rd,
  output logic          data_err,
  output logic          bus_req,
  output logic [AW-1:0] bus_addr,
  output logic          bus_we,
  output logic [DW-1:0] bus_wd,
  output logic [1:0]    bus_size,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rd
);

  state_t        state;
  owner_t        owner;
  owner_t        ptr;
  owner_t        win;
  logic          any_req;
  logic          expire;
  logic          rsp_fire;
  logic [DW-1:0] rsp_rd;
  logic          rsp_err;

  nf_bus_wdog #(
    .TW      (TW),
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .resetn (resetn),
    .clr    (state == RESP),
    .en     (state == BUS),
    .expire (expire)
  );

  always_comb begin
    any_req = instr_req | data_req;
    if (instr_req && data_req) begin
      win = ptr;
    end else if (data_req) begin
      win = OWN_D;
    end else begin
      win = OWN_I;
    end
  end

  // A slave ack in the expiry cycle still wins: the data is real, so no error is reported.
  always_comb begin
    rsp_fire = (state == BUS) && (bus_ack || expire);
    rsp_rd   = bus_ack ? bus_rd : '0;
    rsp_err  = !bus_ack;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      owner     <= OWN_I;
      ptr       <= OWN_I;
      bus_req   <= 1'b0;
      bus_addr  <= '0;
      bus_we    <= 1'b0;
      bus_wd    <= '0;
      bus_size  <= 2'b00;
      instr_ack <= 1'b0;
      instr_rd  <= '0;
      instr_err <= 1'b0;
      data_ack  <= 1'b0;
      data_rd   <= '0;
      data_err  <= 1'b0;
    end else begin
      instr_ack <= 1'b0;
      data_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner   <= win;
            ptr     <= other_owner(win);
            bus_req <= 1'b1;
            state   <= BUS;
            if (win == OWN_I) begin
              bus_addr <= instr_addr;
              bus_we   <= 1'b0;
              bus_wd   <= '0;
              bus_size <= SZ_W;
            end else begin
              bus_addr <= data_addr;
              bus_we   <= data_we;
              bus_wd   <= data_wd;
              bus_size <= data_size;
            end
          end
        end
        BUS: begin
          if (rsp_fire) begin
            bus_req <= 1'b0;
            state   <= RESP;
            if (owner == OWN_I) begin
              instr_ack <= 1'b1;
              instr_rd  <= rsp_rd;
              instr_err <= rsp_err;
            end else begin
              data_ack <= 1'b1;
              data_rd  <= rsp_rd;
              data_err <= rsp_err;
            end
          end
        end
        RESP: begin
          // The ack pulse is live this cycle; any request present now is only looked at in IDLE.
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/nf_bus_arb.md
Name: nf_bus_arb

Overview:
Two-master, one-slave bus arbiter for the nanoFOX core. It lets the instruction-fetch port and the load/store data port share one memory/peripheral bus. Transactions are issued one at a time. Grants are round-robin, each transaction is watchdog-protected against a slave that never acknowledges, and every response is registered back to the requester that owns it.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 255, max cycles waiting for bus_ack before error; 0 disables the watchdog
TW, 8, timeout counter width; TIMEOUT must fit in TW bits

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
instr_req  in  1  fetch request; held with instr_addr until instr_ack
instr_addr  in  AW  fetch address
instr_ack  out  1  one-cycle response strobe to fetch port
instr_rd  out  DW  fetch read data, valid with instr_ack
instr_err  out  1  timeout error, valid with instr_ack
data_req  in  1  load/store request; held with fields until data_ack
data_addr  in  AW  load/store address
data_we  in  1  1 = store
data_wd  in  DW  store data
data_size  in  2  00 byte, 01 half, 10 word
data_ack  out  1  one-cycle response strobe to data port
data_rd  out  DW  load data, valid with data_ack
data_err  out  1  timeout error, valid with data_ack
bus_req  out  1  slave request; held until bus_ack or timeout
bus_addr  out  AW  latched address
bus_we  out  1  latched write enable; 0 for fetch
bus_wd  out  DW  latched write data; 0 for fetch
bus_size  out  2  latched size; 10 for fetch
bus_ack  in  1  slave completion strobe
bus_rd  in  DW  slave read data, valid with bus_ack

Behaviour:
- Clock and reset: single clock clk; resetn asynchronous active-low.
- Reset values: all outputs 0; state IDLE; round-robin pointer = instr; timeout counter 0. Reset mid-transaction aborts silently: no ack is issued, and the requester must re-request.
- States: IDLE, BUS, RESP.
- IDLE:
  - If any req is high, pick the winner, latch its fields into the bus_* registers, set owner, go to BUS.
  - bus_req = 1 from the next cycle.
  - Fetch latches bus_we = 0, bus_wd = 0, bus_size = 10.
- Arbitration:
  - Only one requester high: it wins.
  - Both high: the requester the pointer indicates wins.
  - Pointer moves to the non-winner at each grant.
- BUS:
  - bus_req = 1; fields stable; counter increments each cycle.
  - On bus_ack: capture bus_rd, err = 0, drop bus_req, go to RESP.
  - Else, if TIMEOUT != 0 and counter == TIMEOUT-1: rd = 0, err = 1, drop bus_req, go to RESP.
  - bus_ack takes priority if it arrives in the timeout cycle.
- RESP:
  - The owner's ack = 1 for exactly one cycle, with its rd/err; the other port's ack/rd/err stay 0.
  - All requests are ignored in this cycle. Next state is IDLE; counter is cleared.
- Requester rule: at the edge ending the ack cycle, the requester either deasserts req or presents a new transaction. A req sampled in IDLE is always treated as new.
- Latency: req at cycle 0; bus_req at cycle 1; bus_ack at cycle k >= 1; requester ack at k+1. Minimum 3 cycles per transaction, so at most one transaction per 3 cycles.
- bus_ack outside BUS (late ack after timeout, or a spurious ack) is ignored and has no effect.
- rd/err outputs are held until the next RESP of that port; they are only meaningful while ack is high.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package nf_bus_pkg:
  - state enum (IDLE, BUS, RESP)
  - owner enum (OWN_I, OWN_D)
  - size constants (SZ_B = 00, SZ_H = 01, SZ_W = 10)
- One sub-module, nf_bus_wdog: parameterised TW-bit counter with clear, enable, TIMEOUT compare and expire output; reused by future bus bridges.

Test Plan:
- Single fetch: instr_req with addr 0x0000_0010; slave acks 2 cycles after bus_req with 0x0000_0013 -> bus_addr = 0x10, bus_we = 0, bus_size = 10; instr_ack on cycle 4 with instr_rd = 0x13, instr_err = 0; data_ack stays 0.
- Simultaneous requests after reset: instr_req and data_req high at the same time; slave acks immediately -> fetch granted first, then store. Second bus transaction has bus_we = 1, bus_wd = data_wd, bus_size = data_size. Acks go to the correct ports in order.
- Fairness: both requests held continuously for 6 transactions -> grants alternate I, D, I, D, I, D; neither port waits more than one other transaction.
- Timeout: TIMEOUT = 4; data load and slave never acks -> bus_req high for exactly 4 cycles, then data_ack with data_err = 1, data_rd = 0. A bus_ack pulse injected 2 cycles later is ignored.
- Ack in the timeout cycle: bus_ack on the 4th BUS cycle with TIMEOUT = 4 -> err = 0, rd = bus_rd.
- Reset mid-BUS: assert resetn = 0 while bus_req = 1 -> all outputs 0 immediately. After release, a new fetch completes normally with pointer = instr.
